light_conflict_monitor: RTL and testbench

LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

---
 rtl/light_conflict_monitor.sv | 140 ++++++++++++++
 tb/tb_light_conflict_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/light_conflict_monitor.sv
// Traffic-light safety monitor: latches the first conflict/sequencing violation and drives fail-flash.
// Optional violation counter enabled by defining LCM_VIOL_CNT_EN.
module light_conflict_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int FLASH_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] light_ns,
  input  logic [1:0] light_ew,
  input  logic       walk_signal,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_out,
  output logic [7:0] viol_cnt
);

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b10;
  localparam logic [1:0] ILL = 2'b11;
  localparam logic [7:0] MIN_G8   = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_Y8   = 8'(MIN_YELLOW);
  localparam logic [7:0] DIV_LAST = 8'(FLASH_DIV - 1);

  logic [1:0] prev_ns_p0, prev_ew_p0;
  logic [7:0] dwell_ns_p0, dwell_ew_p0;
  logic [7:0] flash_div_p1;
  logic [2:0] viol_code;
  logic       viol;
  logic       fault_nxt;
  logic [2:0] code_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic bad_trans(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev) return 1'b0;
    return !((prev == RED && cur == GRN) || (prev == GRN && cur == YEL) ||
             (prev == YEL && cur == RED));
  endfunction

  function automatic logic short_yellow(input logic [1:0] prev, input logic [1:0] cur,
                                        input logic [7:0] dwell);
    return (prev == YEL) && (cur == RED) && (dwell < MIN_Y8);
  endfunction

  function automatic logic short_green(input logic [1:0] prev, input logic [1:0] cur,
                                       input logic [7:0] dwell);
    return (prev == GRN) && (cur == YEL) && (dwell < MIN_G8);
  endfunction

  // Stage p0: previous-sample and dwell tracking per direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ns_p0  <= RED;
      prev_ew_p0  <= RED;
      dwell_ns_p0 <= '0;
      dwell_ew_p0 <= '0;
    end else begin
      prev_ns_p0  <= light_ns;
      prev_ew_p0  <= light_ew;
      dwell_ns_p0 <= (light_ns == prev_ns_p0) ? sat_inc(dwell_ns_p0) : 8'd1;
      dwell_ew_p0 <= (light_ew == prev_ew_p0) ? sat_inc(dwell_ew_p0) : 8'd1;
    end
  end

  // Lowest code wins; code 11 counts as non-red for the conflict and walk checks
  always_comb begin
    viol_code = 3'd0;
    if (light_ns != RED && light_ew != RED)
      viol_code = 3'd1;
    else if (walk_signal && (light_ns != RED || light_ew != RED))
      viol_code = 3'd2;
    else if (light_ns == ILL || light_ew == ILL)
      viol_code = 3'd3;
    else if (bad_trans(prev_ns_p0, light_ns) || bad_trans(prev_ew_p0, light_ew))
      viol_code = 3'd4;
    else if (short_yellow(prev_ns_p0, light_ns, dwell_ns_p0) ||
             short_yellow(prev_ew_p0, light_ew, dwell_ew_p0))
      viol_code = 3'd5;
    else if (short_green(prev_ns_p0, light_ns, dwell_ns_p0) ||
             short_green(prev_ew_p0, light_ew, dwell_ew_p0))
      viol_code = 3'd6;
  end

  assign viol = |viol_code;

  // A violation coinciding with a clear re-latches with the fresh code
  always_comb begin
    fault_nxt = fault;
    code_nxt  = fault_code;
    if (viol) begin
      fault_nxt = 1'b1;
      if (!fault || fault_clr) code_nxt = viol_code;
    end else if (fault_clr) begin
      fault_nxt = 1'b0;
      code_nxt  = 3'd0;
    end
  end

  // Stage p1: latched fault and fail-flash divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault        <= 1'b0;
      fault_code   <= 3'd0;
      flash_out    <= 1'b0;
      flash_div_p1 <= '0;
    end else begin
      fault      <= fault_nxt;
      fault_code <= code_nxt;
      if (!fault_nxt || !fault) begin
        flash_out    <= 1'b0;
        flash_div_p1 <= '0;
      end else if (flash_div_p1 == DIV_LAST) begin
        flash_out    <= ~flash_out;
        flash_div_p1 <= '0;
      end else begin
        flash_div_p1 <= flash_div_p1 + 8'd1;
      end
    end
  end

`ifdef LCM_VIOL_CNT_EN
  logic [7:0] viol_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    viol_cnt_p1 <= '0;
    else if (viol) viol_cnt_p1 <= sat_inc(viol_cnt_p1);
  end

  assign viol_cnt = viol_cnt_p1;
`else
  assign viol_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Randomized bench for light_conflict_monitor against a rule-level reference model.
module tb_light_conflict_monitor;
  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int FLASH_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] light_ns, light_ew;
  logic       walk_signal, fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_out;
  logic [7:0] viol_cnt;

  light_conflict_monitor #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW),
                           .FLASH_DIV(FLASH_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .light_ns(light_ns), .light_ew(light_ew),
    .walk_signal(walk_signal), .fault_clr(fault_clr), .fault(fault),
    .fault_code(fault_code), .flash_out(flash_out), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: colours 0 red, 1 green, 2 yellow, 3 illegal
  int succ [4] = '{1, 2, 0, -1};
  int m_prev_ns, m_prev_ew, m_run_ns, m_run_ew;
  int m_fault, m_code, m_t, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dir_code(input int cur, input int prev, input int run);
    if (cur != prev && cur != succ[prev]) return 4;
    if (prev == 2 && cur == 0 && run < MIN_YELLOW) return 5;
    if (prev == 1 && cur == 2 && run < MIN_GREEN) return 6;
    return 0;
  endfunction

  function automatic int pick(input int best, input int c);
    if (c == 0) return best;
    if (best == 0 || c < best) return c;
    return best;
  endfunction

  function automatic int model_viol(input int ns, input int ew, input int walk);
    int best;
    best = 0;
    if (ns != 0 && ew != 0) best = pick(best, 1);
    if (walk != 0 && (ns != 0 || ew != 0)) best = pick(best, 2);
    if (ns == 3 || ew == 3) best = pick(best, 3);
    best = pick(best, dir_code(ns, m_prev_ns, m_run_ns));
    best = pick(best, dir_code(ew, m_prev_ew, m_run_ew));
    return best;
  endfunction

  task automatic model_reset();
    m_prev_ns = 0; m_prev_ew = 0; m_run_ns = 0; m_run_ew = 0;
    m_fault = 0; m_code = 0; m_t = 0; m_cnt = 0;
  endtask

  task automatic step(input int ns, input int ew, input int walk, input int clr);
    int v;
    light_ns    = 2'(ns);
    light_ew    = 2'(ew);
    walk_signal = 1'(walk);
    fault_clr   = 1'(clr);
    @(posedge clk);
    v = model_viol(ns, ew, walk);
    if (v != 0) begin
      if (m_fault == 0) begin
        m_fault = 1; m_code = v; m_t = 0;
      end else begin
        if (clr != 0) m_code = v;
        m_t++;
      end
`ifdef LCM_VIOL_CNT_EN
      if (m_cnt < 255) m_cnt++;
`endif
    end else if (clr != 0) begin
      m_fault = 0; m_code = 0; m_t = 0;
    end else if (m_fault != 0) begin
      m_t++;
    end
    m_run_ns  = (ns == m_prev_ns) ? ((m_run_ns < 255) ? m_run_ns + 1 : 255) : 1;
    m_run_ew  = (ew == m_prev_ew) ? ((m_run_ew < 255) ? m_run_ew + 1 : 255) : 1;
    m_prev_ns = ns;
    m_prev_ew = ew;
    #1;
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("flash_out", 32'(flash_out), (m_fault != 0) ? 32'((m_t / FLASH_DIV) % 2) : 32'd0);
    chk("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_flash", 32'(flash_out), 32'd0);
    chk("rst_cnt", 32'(viol_cnt), 32'd0);
    model_reset();
    light_ns = 2'b00; light_ew = 2'b00; walk_signal = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_dir(input int is_ns, input int g, input int y);
    for (int i = 0; i < g; i++) step(is_ns ? 1 : 0, is_ns ? 0 : 1, 0, 0);
    for (int i = 0; i < y; i++) step(is_ns ? 2 : 0, is_ns ? 0 : 2, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
  endtask

  function automatic int rnd_next(input int prev);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 70) return prev;
    if (r < 92) return (prev == 3) ? 0 : succ[prev];
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    rst_n = 1'b1;
    light_ns = 2'b00; light_ew = 2'b00; walk_signal = 1'b0; fault_clr = 1'b0;
    model_reset();
    do_reset();

    // legal full cycle on both directions
    step(0, 0, 0, 0);
    run_dir(1, 6, 3);
    run_dir(0, 6, 3);
    chk("legal_fault", 32'(fault), 32'd0);
    chk("legal_flash", 32'(flash_out), 32'd0);

    // conflict, then watch flash over 13 cycles
    step(1, 1, 0, 0);
    chk("conflict_code", 32'(fault_code), 32'd1);
    for (int i = 1; i <= 13; i++) begin
      step(0, 0, 0, 0);
      if (i == 4) chk("flash_at4", 32'(flash_out), 32'd1);
      if (i == 8) chk("flash_at8", 32'(flash_out), 32'd0);
    end
    do_reset();

    // short yellow, then a later conflict must not overwrite
    run_dir(1, 5, 1);
    chk("short_yel_code", 32'(fault_code), 32'd5);
    step(1, 1, 0, 0);
    chk("sticky_code", 32'(fault_code), 32'd5);
    do_reset();

    // first sample yellow is an illegal transition from red
    step(2, 0, 0, 0);
    chk("first_yellow", 32'(fault_code), 32'd4);
    do_reset();

    // skipped yellow, then clear while all red
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("skip_code", 32'(fault_code), 32'd4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_code", 32'(fault_code), 32'd0);
    chk("clr_flash", 32'(flash_out), 32'd0);

    // walk with illegal lamp; clear in same cycle loses
    step(3, 0, 1, 1);
    chk("prio_code", 32'(fault_code), 32'd2);
    chk("prio_fault", 32'(fault), 32'd1);
    do_reset();

    // long conflict run saturates the counter, then reset mid-run
    for (int i = 0; i < 300; i++) step(1, 1, 0, (i % 37 == 5) ? 1 : 0);
`ifdef LCM_VIOL_CNT_EN
    chk("cnt_sat", 32'(viol_cnt), 32'd255);
`else
    chk("cnt_off", 32'(viol_cnt), 32'd0);
`endif
    do_reset();

    // randomized traffic with clears and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int ns, ew, wk, cl;
      ns = rnd_next(m_prev_ns);
      ew = rnd_next(m_prev_ew);
      wk = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cl = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(ns, ew, wk, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
